tdm_frame_scheduler: RTL and testbench

//   Transmit-side TDM frame controller. Generates tdm_clk, tdm_sync and tdm_data for the 5-channel TDM link.

---
 rtl/tdm_frame_scheduler.sv | 145 ++++++++++++++
 tb/tb_tdm_frame_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_frame_scheduler.sv
// Transmit-side TDM frame controller: snapshots one word per channel at frame start,
// then sends a sync bit and NUM_CH MSB-first slots on a divided bit clock.
module tdm_frame_scheduler #(
  parameter int unsigned              NUM_CH   = 5,
  parameter int unsigned              SLOT_W   = 16,
  parameter int unsigned              CLK_DIV  = 4,
  parameter int unsigned              GAP_BITS = 0,
  parameter logic [SLOT_W-1:0]        FILL     = '0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           ch_valid,
  input  logic [NUM_CH*SLOT_W-1:0]    ch_data,
  output logic [NUM_CH-1:0]           ch_ack,
  output logic [NUM_CH-1:0]           underrun,
  output logic                        tdm_clk,
  output logic                        tdm_sync,
  output logic                        tdm_data,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int unsigned FRAME_BITS = NUM_CH * SLOT_W;
  localparam int unsigned BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam bit            HAS_GAP  = (GAP_BITS != 0);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_SHIFT, S_GAP} state_t;

  state_t                r_state;
  logic [DW-1:0]         r_div;
  logic [BW-1:0]         r_bit;
  logic [GW-1:0]         r_gap;
  logic [FRAME_BITS-1:0] r_snap;

  logic [DW-1:0]         w_div_next;
  logic                  w_wrap;
  logic                  w_frame_end;
  logic                  w_gap_end;
  logic                  w_period_end;
  logic                  w_go_sync;
  logic                  w_go_idle;
  logic [FRAME_BITS-1:0] w_capture;

  // Snapshot is held as one shift register with ch0 in the top slot, so the next
  // serial bit is always the MSB instead of a slot/bit index computed from r_bit.
  always_comb begin
    w_wrap       = (r_div == DIV_LAST);
    w_div_next   = w_wrap ? '0 : r_div + DW'(1);
    w_frame_end  = (r_state == S_SHIFT) && w_wrap && (r_bit == BIT_LAST);
    w_gap_end    = HAS_GAP && (r_state == S_GAP) && w_wrap && (r_gap == GAP_LAST);
    w_period_end = (w_frame_end && !HAS_GAP) || w_gap_end;
    w_go_sync    = ((r_state == S_IDLE) || w_period_end) && enable;
    w_go_idle    = w_period_end && !enable;
    w_capture    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_capture[(NUM_CH-1-i)*SLOT_W +: SLOT_W] =
        ch_valid[i] ? ch_data[i*SLOT_W +: SLOT_W] : FILL;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_gap      <= '0;
      r_snap     <= '0;
      ch_ack     <= '0;
      underrun   <= '0;
      tdm_clk    <= 1'b0;
      tdm_sync   <= 1'b0;
      tdm_data   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ch_ack     <= '0;
      underrun   <= '0;
      frame_done <= 1'b0;

      if (r_state != S_IDLE) begin
        r_div   <= w_div_next;
        tdm_clk <= (w_div_next >= DIV_HALF);
      end

      if (w_wrap) begin
        case (r_state)
          S_SYNC: begin
            r_state  <= S_SHIFT;
            r_bit    <= '0;
            tdm_sync <= 1'b0;
            tdm_data <= r_snap[FRAME_BITS-1];
            r_snap   <= {r_snap[FRAME_BITS-2:0], 1'b0};
          end
          S_SHIFT: begin
            if (r_bit != BIT_LAST) begin
              r_bit    <= r_bit + BW'(1);
              tdm_data <= r_snap[FRAME_BITS-1];
              r_snap   <= {r_snap[FRAME_BITS-2:0], 1'b0};
            end else begin
              frame_done <= 1'b1;
              r_bit      <= '0;
              tdm_data   <= 1'b0;
              if (HAS_GAP) begin
                r_state <= S_GAP;
                r_gap   <= '0;
              end
            end
          end
          S_GAP: begin
            if (r_gap != GAP_LAST) r_gap <= r_gap + GW'(1);
          end
          default: ;
        endcase
      end

      // Frame start and stop override the per-state updates above.
      if (w_go_sync) begin
        r_state  <= S_SYNC;
        r_div    <= '0;
        tdm_clk  <= 1'b0;
        tdm_sync <= 1'b1;
        tdm_data <= 1'b0;
        busy     <= 1'b1;
        r_snap   <= w_capture;
        ch_ack   <= ch_valid;
        underrun <= ~ch_valid;
      end else if (w_go_idle) begin
        r_state  <= S_IDLE;
        r_div    <= '0;
        tdm_clk  <= 1'b0;
        tdm_sync <= 1'b0;
        tdm_data <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// Bench for tdm_frame_scheduler: a timing/bit-stream model built from the frame rules
// scores two instances (no gap, 3-bit gap) under fixed and randomized producers.
module tb_tdm_frame_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        en0, en3;
  logic [4:0]  ch_valid;
  logic [79:0] ch_data;

  logic [4:0]  d0_ack, d0_ur, d3_ack, d3_ur;
  logic        d0_clk, d0_sync, d0_data, d0_done, d0_busy;
  logic        d3_clk, d3_sync, d3_data, d3_done, d3_busy;

  int checks = 0;
  int failures = 0;
  int sel = 0;

  logic [4:0] s_ack, s_ur;
  logic       s_clk, s_sync, s_data, s_done, s_busy;

  int err_clk, err_busy, err_ack, err_done, err_stream, err_stable;
  int n_frames, n_done, n_ack, done_t, last_busy_t;
  logic [4:0] ack0, ur0;

  always #5 clock = ~clock;

  tdm_frame_scheduler #(.NUM_CH(5), .SLOT_W(16), .CLK_DIV(4), .GAP_BITS(0), .FILL(16'h0000)) dut0 (
    .clock(clock), .reset_n(reset_n), .enable(en0), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ack(d0_ack), .underrun(d0_ur), .tdm_clk(d0_clk), .tdm_sync(d0_sync), .tdm_data(d0_data),
    .frame_done(d0_done), .busy(d0_busy));

  tdm_frame_scheduler #(.NUM_CH(5), .SLOT_W(16), .CLK_DIV(4), .GAP_BITS(3), .FILL(16'h0000)) dut3 (
    .clock(clock), .reset_n(reset_n), .enable(en3), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ack(d3_ack), .underrun(d3_ur), .tdm_clk(d3_clk), .tdm_sync(d3_sync), .tdm_data(d3_data),
    .frame_done(d3_done), .busy(d3_busy));

  always_comb begin
    if (sel == 1) begin
      s_ack = d3_ack; s_ur = d3_ur; s_clk = d3_clk; s_sync = d3_sync;
      s_data = d3_data; s_done = d3_done; s_busy = d3_busy;
    end else begin
      s_ack = d0_ack; s_ur = d0_ur; s_clk = d0_clk; s_sync = d0_sync;
      s_data = d0_data; s_done = d0_done; s_busy = d0_busy;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_en(input int which, input logic v);
    if (which == 1) en3 = v; else en0 = v;
  endtask

  task automatic rand_data();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    ch_data = r[79:0];
  endtask

  // Model: a frame occupies 4*(81+gap) clocks from its start edge; bit period p spans
  // clocks 4p..4p+3, the bit clock is high on phases 2,3, and the receiver samples at phase 2.
  task automatic watch(input int which, input int gap, input int n, input int drop_at, input bit rand_valid);
    int          fstart;
    int          ph;
    bit          mbusy;
    bit          start;
    bit          exp_done;
    logic        pre_en;
    logic [4:0]  pre_v;
    logic [79:0] pre_d;
    logic [15:0] w;
    logic [1:0]  q[$];
    logic [1:0]  hold1, hold2, e;
    err_clk = 0; err_busy = 0; err_ack = 0; err_done = 0; err_stream = 0; err_stable = 0;
    n_frames = 0; n_done = 0; n_ack = 0; done_t = -1; last_busy_t = -1;
    ack0 = 'x; ur0 = 'x;
    sel = which; mbusy = 0; fstart = 0; hold1 = 0; hold2 = 0;
    set_en(which, 1'b1);
    for (int t = 0; t < n; t++) begin
      pre_en = (which == 1) ? en3 : en0;
      pre_v = ch_valid;
      pre_d = ch_data;
      tick();
      start = 0;
      exp_done = mbusy && (t == fstart + 324);
      if (!mbusy) begin
        if (pre_en) start = 1;
      end else if (t == fstart + 4 * (81 + gap)) begin
        if (pre_en) start = 1; else mbusy = 0;
      end
      if (start) begin
        mbusy = 1; fstart = t; n_frames++;
        if (n_frames == 1) begin ack0 = s_ack; ur0 = s_ur; end
        q.push_back(2'b10);
        for (int ch = 0; ch < 5; ch++) begin
          w = pre_v[ch] ? pre_d[ch*16 +: 16] : 16'h0000;
          for (int b = 15; b >= 0; b--) q.push_back({1'b0, w[b]});
        end
        for (int g = 0; g < gap; g++) q.push_back(2'b00);
      end
      ph = mbusy ? (t - fstart) % 4 : 0;
      if (s_clk !== (mbusy && ph >= 2)) err_clk++;
      if (s_busy !== mbusy) err_busy++;
      if (s_busy === 1'b1) last_busy_t = t;
      if (s_ack !== (start ? pre_v : 5'h00)) err_ack++;
      if (s_ur !== (start ? ~pre_v : 5'h00)) err_ack++;
      if (s_ack !== 5'h00) n_ack++;
      if (s_done !== exp_done) err_done++;
      if (s_done === 1'b1) begin n_done++; done_t = t; end
      if (!mbusy) begin
        if ({s_sync, s_data} !== 2'b00) err_stream++;
      end else if (ph == 1) begin
        hold1 = {s_sync, s_data};
      end else if (ph == 2) begin
        hold2 = {s_sync, s_data};
        if (q.size() == 0) err_stream++;
        else begin
          e = q.pop_front();
          if (hold2 !== e) err_stream++;
        end
        if (hold1 !== hold2) err_stable++;
      end else if (ph == 3) begin
        if ({s_sync, s_data} !== hold2) err_stable++;
      end
      if (start) begin
        rand_data();
        if (rand_valid) ch_valid = 5'($urandom());
      end
      if (t == drop_at) set_en(which, 1'b0);
    end
    err_stream += q.size();
    set_en(which, 1'b0);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({d0_ack, d0_ur, d0_clk, d0_sync, d0_data, d0_done, d0_busy} !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs_dut0 got %h expected 0", {d0_ack, d0_ur, d0_clk, d0_sync, d0_data, d0_done, d0_busy});
    end
    checks++;
    if ({d3_ack, d3_ur, d3_clk, d3_sync, d3_data, d3_done, d3_busy} !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs_dut3 got %h expected 0", {d3_ack, d3_ur, d3_clk, d3_sync, d3_data, d3_done, d3_busy});
    end
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({d0_busy, d0_clk, d3_busy, d3_clk} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle cycle %0d got busy/clk %b expected 0000", i, {d0_busy, d0_clk, d3_busy, d3_clk});
      end
    end
  endtask

  task automatic test_single_frame();
    ch_valid = 5'h1F;
    ch_data = {16'h8000, 16'h0001, 16'hFFFF, 16'h1234, 16'hA5A5};
    watch(0, 0, 340, 0, 1'b0);
    checks++; if (ack0 !== 5'h1F) begin failures++; $display("FAIL single_ack got %h expected 1f", ack0); end
    checks++; if (ur0 !== 5'h00) begin failures++; $display("FAIL single_underrun got %h expected 00", ur0); end
    checks++; if (done_t !== 324) begin failures++; $display("FAIL single_done_time got %0d expected 324", done_t); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL single_done_count got %0d expected 1", n_done); end
    checks++; if (err_stream !== 0) begin failures++; $display("FAIL single_stream mismatches %0d expected 0", err_stream); end
    checks++; if (err_clk !== 0) begin failures++; $display("FAIL single_tdm_clk mismatches %0d expected 0", err_clk); end
    checks++; if (err_busy !== 0) begin failures++; $display("FAIL single_busy mismatches %0d expected 0", err_busy); end
    checks++; if (err_ack + err_done !== 0) begin failures++; $display("FAIL single_pulses mismatches %0d expected 0", err_ack + err_done); end
    checks++; if (err_stable !== 0) begin failures++; $display("FAIL single_sample_stability mismatches %0d expected 0", err_stable); end
  endtask

  task automatic test_underrun();
    ch_valid = 5'h1B;
    rand_data();
    watch(0, 0, 340, 0, 1'b0);
    checks++; if (ack0 !== 5'h1B) begin failures++; $display("FAIL underrun_ack got %h expected 1b", ack0); end
    checks++; if (ur0 !== 5'h04) begin failures++; $display("FAIL underrun_flags got %h expected 04", ur0); end
    checks++; if (err_stream !== 0) begin failures++; $display("FAIL underrun_fill_stream mismatches %0d expected 0", err_stream); end
    checks++; if (err_ack !== 0) begin failures++; $display("FAIL underrun_pulses mismatches %0d expected 0", err_ack); end
  endtask

  task automatic test_back_to_back();
    ch_valid = 5'($urandom());
    rand_data();
    watch(0, 0, 3 * 324 + 30, 2 * 324 + 5, 1'b1);
    checks++; if (n_frames !== 3) begin failures++; $display("FAIL b2b_frames got %0d expected 3", n_frames); end
    checks++; if (n_done !== 3) begin failures++; $display("FAIL b2b_done_count got %0d expected 3", n_done); end
    checks++; if (done_t !== 972) begin failures++; $display("FAIL b2b_last_done got %0d expected 972", done_t); end
    checks++; if (err_clk !== 0) begin failures++; $display("FAIL b2b_tdm_clk mismatches %0d expected 0", err_clk); end
    checks++; if (err_stream !== 0) begin failures++; $display("FAIL b2b_stream mismatches %0d expected 0", err_stream); end
    checks++; if (err_ack + err_busy + err_done + err_stable !== 0) begin
      failures++; $display("FAIL b2b_control mismatches %0d expected 0", err_ack + err_busy + err_done + err_stable);
    end
  endtask

  task automatic test_gap_drop();
    ch_valid = 5'h1F;
    rand_data();
    watch(1, 3, 324 + 12 + 30, 100, 1'b0);
    checks++; if (n_ack !== 1) begin failures++; $display("FAIL gap_ack_pulses got %0d expected 1", n_ack); end
    checks++; if (done_t !== 324) begin failures++; $display("FAIL gap_done_time got %0d expected 324", done_t); end
    checks++; if (last_busy_t !== 335) begin failures++; $display("FAIL gap_last_busy got %0d expected 335", last_busy_t); end
    checks++; if (err_stream + err_clk !== 0) begin failures++; $display("FAIL gap_stream mismatches %0d expected 0", err_stream + err_clk); end
    checks++; if (err_ack + err_busy + err_done !== 0) begin
      failures++; $display("FAIL gap_control mismatches %0d expected 0", err_ack + err_busy + err_done);
    end
  endtask

  task automatic test_random();
    int drop;
    for (int r = 0; r < 2; r++) begin
      ch_valid = 5'($urandom());
      rand_data();
      drop = (r == 0) ? int'($urandom_range(330, 640)) : int'($urandom_range(340, 670));
      watch(r, (r == 0) ? 0 : 3, (r == 0) ? 3 * 324 + 20 : 3 * 336 + 20, drop, 1'b1);
      checks++; if (n_frames !== 2) begin failures++; $display("FAIL random%0d_frames got %0d expected 2", r, n_frames); end
      checks++; if (err_stream + err_clk + err_stable !== 0) begin
        failures++; $display("FAIL random%0d_stream mismatches %0d expected 0", r, err_stream + err_clk + err_stable);
      end
      checks++; if (err_ack + err_busy + err_done !== 0) begin
        failures++; $display("FAIL random%0d_control mismatches %0d expected 0", r, err_ack + err_busy + err_done);
      end
    end
  endtask

  task automatic test_reset_midframe();
    ch_valid = 5'h1F;
    ch_data = {16'h8000, 16'h0001, 16'hFFFF, 16'h1234, 16'hFFFF};
    en0 = 1'b1;
    tick();
    en0 = 1'b0;
    repeat (62) tick();
    checks++;
    if (d0_busy !== 1'b1) begin failures++; $display("FAIL midframe_busy_before_reset got %b expected 1", d0_busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({d0_ack, d0_ur, d0_clk, d0_sync, d0_data, d0_done, d0_busy} !== 15'h0) begin
      failures++;
      $display("FAIL midframe_async_reset got %h expected 0", {d0_ack, d0_ur, d0_clk, d0_sync, d0_data, d0_done, d0_busy});
    end
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({d0_busy, d0_clk, d0_done, d0_ack, d0_ur} !== 13'h0) begin
        failures++;
        $display("FAIL midframe_after_release cycle %0d got %h expected 0", i, {d0_busy, d0_clk, d0_done, d0_ack, d0_ur});
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en0 = 1'b0;
    en3 = 1'b0;
    ch_valid = '0;
    ch_data = '0;
    test_reset();
    test_single_frame();
    test_underrun();
    test_back_to_back();
    test_gap_drop();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
